// File: rtl/arf104b256e1r1w0cbbehcaa4acw_bcam_mbist_matchchk.sv
// CAM MBIST match checker: aligns BIST compare requests to match-line latency, compares and compacts results.
// Compare/read-data paths are combinational in the aligned cycle; status updates one edge later; no backpressure.
module arf104b256e1r1w0cbbehcaa4acw_bcam_mbist_matchchk #(
  parameter int RF_ENTRIES = 128,
  parameter int RF_DWIDTH  = 72,
  parameter int RF_AWIDTH  = 7,
  parameter int RD_PORTS   = 1,
  parameter int CM_PORTS   = 2,
  parameter int ADDR_LAT   = 2,
  parameter int FCNT_W     = 8,
  localparam int PORT_W    = (CM_PORTS > 1) ? $clog2(CM_PORTS) : 1
) (
  input  logic                                   bist_clk,
  input  logic                                   bist_rst,
  input  logic                                   BIST_CM_MODE_RF_IN,
  input  logic [CM_PORTS-1:0]                    BIST_CM_CMP_EN_RF_IN,
  input  logic [CM_PORTS-1:0][1:0]               BIST_CM_MATCH_SEL_RF_IN,
  input  logic [CM_PORTS-1:0][RF_AWIDTH-1:0]     BIST_RD_ADDR_RF_IN,
  input  logic                                   BIST_CLR_STATUS_RF_IN,
  input  logic [CM_PORTS-1:0][RF_ENTRIES-1:0]    CM_MATCH_DATA,
  input  logic [RD_PORTS-1:0][RF_DWIDTH-1:0]     RD_DATA_RF_IN,
  output logic [RD_PORTS-1:0][RF_DWIDTH-1:0]     RD_DATA_RF_OUT,
  output logic [CM_PORTS-1:0][RF_ENTRIES-1:0]    CM_MATCH_REF_DATA,
  output logic [CM_PORTS-1:0]                    CM_FAIL_STICKY,
  output logic [FCNT_W-1:0]                      CM_FAIL_CNT,
  output logic                                   CM_FIRST_FAIL_VLD,
  output logic [PORT_W-1:0]                      CM_FIRST_FAIL_PORT,
  output logic [RF_AWIDTH-1:0]                   CM_FIRST_FAIL_ADDR,
  output logic [RF_AWIDTH-1:0]                   CM_FIRST_FAIL_ENTRY
);

  localparam int SUM_W = FCNT_W + $clog2(CM_PORTS + 1);

  logic [ADDR_LAT-1:0][CM_PORTS-1:0]                en_pipe_d, en_pipe_q;
  logic [ADDR_LAT-1:0][CM_PORTS-1:0][1:0]           sel_pipe_d, sel_pipe_q;
  logic [ADDR_LAT-1:0][CM_PORTS-1:0][RF_AWIDTH-1:0] addr_pipe_d, addr_pipe_q;

  logic [CM_PORTS-1:0]                 en_a;
  logic [CM_PORTS-1:0][1:0]            sel_a;
  logic [CM_PORTS-1:0][RF_AWIDTH-1:0]  addr_a;

  logic [CM_PORTS-1:0][RF_ENTRIES-1:0] one_hot;
  logic [CM_PORTS-1:0][RF_ENTRIES-1:0] ref_vec;
  logic [CM_PORTS-1:0][RF_ENTRIES-1:0] cmp_vec;
  logic [CM_PORTS-1:0][RF_DWIDTH-1:0]  compact;
  logic [CM_PORTS-1:0]                 fail;

  logic [PORT_W-1:0]    ff_port_sel;
  logic [RF_AWIDTH-1:0] ff_addr_sel;
  logic [RF_AWIDTH-1:0] ff_entry_sel;

  logic [CM_PORTS-1:0]  sticky_d, sticky_q;
  logic [FCNT_W-1:0]    cnt_d, cnt_q;
  logic [SUM_W-1:0]     cnt_sum;

  typedef enum logic {ST_IDLE = 1'b0, ST_CAPT = 1'b1} cap_state_e;
  cap_state_e           state_q;
  logic [PORT_W-1:0]    ff_port_q;
  logic [RF_AWIDTH-1:0] ff_addr_q;
  logic [RF_AWIDTH-1:0] ff_entry_q;

  // Request alignment: stage 0 takes the live request, last stage lines up with match data.
  always_comb begin
    en_pipe_d      = en_pipe_q;
    sel_pipe_d     = sel_pipe_q;
    addr_pipe_d    = addr_pipe_q;
    en_pipe_d[0]   = BIST_CM_CMP_EN_RF_IN;
    sel_pipe_d[0]  = BIST_CM_MATCH_SEL_RF_IN;
    addr_pipe_d[0] = BIST_RD_ADDR_RF_IN;
    for (int s = 1; s < ADDR_LAT; s++) begin
      en_pipe_d[s]   = en_pipe_q[s-1];
      sel_pipe_d[s]  = sel_pipe_q[s-1];
      addr_pipe_d[s] = addr_pipe_q[s-1];
    end
  end

  always_ff @(posedge bist_clk) begin
    if (bist_rst) begin
      en_pipe_q   <= '0;
      sel_pipe_q  <= '0;
      addr_pipe_q <= '0;
    end else begin
      en_pipe_q   <= en_pipe_d;
      sel_pipe_q  <= sel_pipe_d;
      addr_pipe_q <= addr_pipe_d;
    end
  end

  assign en_a   = en_pipe_q[ADDR_LAT-1];
  assign sel_a  = sel_pipe_q[ADDR_LAT-1];
  assign addr_a = addr_pipe_q[ADDR_LAT-1];

  // Out-of-range addresses produce an empty one-hot, so SEL=10 degenerates to all-ones.
  always_comb begin
    one_hot = '0;
    ref_vec = '0;
    cmp_vec = '0;
    fail    = '0;
    for (int p = 0; p < CM_PORTS; p++) begin
      for (int i = 0; i < RF_ENTRIES; i++) begin
        one_hot[p][i] = (32'(addr_a[p]) == 32'(i));
      end
      case (sel_a[p])
        2'b00:   ref_vec[p] = '1;
        2'b01:   ref_vec[p] = one_hot[p];
        2'b10:   ref_vec[p] = ~one_hot[p];
        default: ref_vec[p] = '0;
      endcase
      cmp_vec[p] = ref_vec[p] ^ CM_MATCH_DATA[p];
      fail[p]    = en_a[p] & (|cmp_vec[p]);
    end
  end

  assign CM_MATCH_REF_DATA = ref_vec;

  generate
    if (RF_DWIDTH <= RF_ENTRIES) begin : g_fold
      always_comb begin
        compact = '0;
        for (int p = 0; p < CM_PORTS; p++) begin
          for (int i = 0; i < RF_ENTRIES; i++) begin
            compact[p][i % RF_DWIDTH] = compact[p][i % RF_DWIDTH] | cmp_vec[p][i];
          end
        end
      end
    end else begin : g_pad
      always_comb begin
        compact = '0;
        for (int p = 0; p < CM_PORTS; p++) begin
          compact[p][RF_DWIDTH-1 -: RF_ENTRIES] = cmp_vec[p];
        end
      end
    end
  endgenerate

  // Read ports beyond the compare-port count mirror port 0's compare result.
  for (genvar r = 0; r < RD_PORTS; r++) begin : g_rd
    localparam int SRC = (r < CM_PORTS) ? r : 0;
    assign RD_DATA_RF_OUT[r] = BIST_CM_MODE_RF_IN ? compact[SRC] : RD_DATA_RF_IN[r];
  end

  // Descending scans leave the lowest failing port and its lowest mismatching entry.
  always_comb begin
    ff_port_sel  = '0;
    ff_addr_sel  = '0;
    ff_entry_sel = '0;
    for (int p = CM_PORTS - 1; p >= 0; p--) begin
      if (fail[p]) begin
        ff_port_sel = PORT_W'(p);
        ff_addr_sel = addr_a[p];
        for (int i = RF_ENTRIES - 1; i >= 0; i--) begin
          if (cmp_vec[p][i]) ff_entry_sel = RF_AWIDTH'(i);
        end
      end
    end
  end

  always_comb begin
    cnt_sum = SUM_W'(cnt_q);
    for (int p = 0; p < CM_PORTS; p++) begin
      cnt_sum = cnt_sum + SUM_W'(fail[p]);
    end
    sticky_d = sticky_q | fail;
    if (|cnt_sum[SUM_W-1:FCNT_W]) cnt_d = '1;
    else                          cnt_d = cnt_sum[FCNT_W-1:0];
    if (BIST_CLR_STATUS_RF_IN) begin
      sticky_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge bist_clk) begin
    if (bist_rst) begin
      sticky_q <= '0;
      cnt_q    <= '0;
    end else begin
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge bist_clk) begin
    if (bist_rst || BIST_CLR_STATUS_RF_IN) begin
      state_q    <= ST_IDLE;
      ff_port_q  <= '0;
      ff_addr_q  <= '0;
      ff_entry_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|fail) begin
            state_q    <= ST_CAPT;
            ff_port_q  <= ff_port_sel;
            ff_addr_q  <= ff_addr_sel;
            ff_entry_q <= ff_entry_sel;
          end
        end
        ST_CAPT: state_q <= ST_CAPT;
      endcase
    end
  end

  assign CM_FAIL_STICKY      = sticky_q;
  assign CM_FAIL_CNT         = cnt_q;
  assign CM_FIRST_FAIL_VLD   = (state_q == ST_CAPT);
  assign CM_FIRST_FAIL_PORT  = ff_port_q;
  assign CM_FIRST_FAIL_ADDR  = ff_addr_q;
  assign CM_FIRST_FAIL_ENTRY = ff_entry_q;

endmodule

// File: tb/tb_arf104b256e1r1w0cbbehcaa4acw_bcam_mbist_matchchk.sv
// Bench: randomized stimulus with a queue-based scoreboard for a ragged-fold instance,
// plus directed checks on a zero-padded wide-data instance with a small fail counter.
module tb_arf104b256e1r1w0cbbehcaa4acw_bcam_mbist_matchchk;

  localparam int ENT  = 100;
  localparam int DW   = 72;
  localparam int AW   = 7;
  localparam int RDP  = 3;
  localparam int CMP  = 2;
  localparam int LAT  = 2;
  localparam int FW   = 5;
  localparam int PW   = 1;
  localparam int NCYC = 2500;

  localparam int W_ENT = 64;
  localparam int W_DW  = 72;
  localparam int W_AW  = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                         rst, mode, clr;
  logic [CMP-1:0]               en;
  logic [CMP-1:0][1:0]          sel;
  logic [CMP-1:0][AW-1:0]       addr;
  logic [CMP-1:0][ENT-1:0]      match;
  logic [RDP-1:0][DW-1:0]       rd_in, rd_out;
  logic [CMP-1:0][ENT-1:0]      ref_out;
  logic [CMP-1:0]               sticky;
  logic [FW-1:0]                cnt;
  logic                         ff_vld;
  logic [PW-1:0]                ff_port;
  logic [AW-1:0]                ff_addr, ff_entry;

  logic                         w_rst, w_mode, w_clr;
  logic [0:0]                   w_en;
  logic [0:0][1:0]              w_sel;
  logic [0:0][W_AW-1:0]         w_addr;
  logic [0:0][W_ENT-1:0]        w_match, w_ref;
  logic [0:0][W_DW-1:0]         w_rd_in, w_rd_out;
  logic [0:0]                   w_sticky;
  logic [3:0]                   w_cnt;
  logic                         w_vld;
  logic [0:0]                   w_port;
  logic [W_AW-1:0]              w_ffaddr, w_ffentry;

  arf104b256e1r1w0cbbehcaa4acw_bcam_mbist_matchchk #(
    .RF_ENTRIES(ENT), .RF_DWIDTH(DW), .RF_AWIDTH(AW), .RD_PORTS(RDP),
    .CM_PORTS(CMP), .ADDR_LAT(LAT), .FCNT_W(FW)
  ) dut (
    .bist_clk(clk), .bist_rst(rst),
    .BIST_CM_MODE_RF_IN(mode), .BIST_CM_CMP_EN_RF_IN(en),
    .BIST_CM_MATCH_SEL_RF_IN(sel), .BIST_RD_ADDR_RF_IN(addr),
    .BIST_CLR_STATUS_RF_IN(clr), .CM_MATCH_DATA(match),
    .RD_DATA_RF_IN(rd_in), .RD_DATA_RF_OUT(rd_out),
    .CM_MATCH_REF_DATA(ref_out), .CM_FAIL_STICKY(sticky), .CM_FAIL_CNT(cnt),
    .CM_FIRST_FAIL_VLD(ff_vld), .CM_FIRST_FAIL_PORT(ff_port),
    .CM_FIRST_FAIL_ADDR(ff_addr), .CM_FIRST_FAIL_ENTRY(ff_entry)
  );

  arf104b256e1r1w0cbbehcaa4acw_bcam_mbist_matchchk #(
    .RF_ENTRIES(W_ENT), .RF_DWIDTH(W_DW), .RF_AWIDTH(W_AW), .RD_PORTS(1),
    .CM_PORTS(1), .ADDR_LAT(1), .FCNT_W(4)
  ) dut_wide (
    .bist_clk(clk), .bist_rst(w_rst),
    .BIST_CM_MODE_RF_IN(w_mode), .BIST_CM_CMP_EN_RF_IN(w_en),
    .BIST_CM_MATCH_SEL_RF_IN(w_sel), .BIST_RD_ADDR_RF_IN(w_addr),
    .BIST_CLR_STATUS_RF_IN(w_clr), .CM_MATCH_DATA(w_match),
    .RD_DATA_RF_IN(w_rd_in), .RD_DATA_RF_OUT(w_rd_out),
    .CM_MATCH_REF_DATA(w_ref), .CM_FAIL_STICKY(w_sticky), .CM_FAIL_CNT(w_cnt),
    .CM_FIRST_FAIL_VLD(w_vld), .CM_FIRST_FAIL_PORT(w_port),
    .CM_FIRST_FAIL_ADDR(w_ffaddr), .CM_FIRST_FAIL_ENTRY(w_ffentry)
  );

  typedef struct {
    int                      cyc;
    logic [CMP-1:0][ENT-1:0] refv;
    logic [RDP-1:0][DW-1:0]  rdo;
  } comb_exp_t;

  typedef struct {
    int             cyc;
    logic [CMP-1:0] sticky;
    logic [FW-1:0]  cnt;
    logic           vld;
    logic [PW-1:0]  port;
    logic [AW-1:0]  addr;
    logic [AW-1:0]  entry;
  } stat_exp_t;

  comb_exp_t comb_q[$];
  stat_exp_t stat_q[$];
  comb_exp_t ce, ce_mon;
  stat_exp_t se, se_mon;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = -1;

  function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Expected-pattern rule from the select code and the aligned address.
  function automatic logic [ENT-1:0] ref_pat(logic [1:0] s, int a);
    logic [ENT-1:0] oh, res;
    oh = '0;
    if (a < ENT) oh[a] = 1'b1;
    case (s)
      2'b00:   res = '1;
      2'b01:   res = oh;
      2'b10:   res = ~oh;
      default: res = '0;
    endcase
    return res;
  endfunction

  function automatic logic [DW-1:0] fold(logic [ENT-1:0] c);
    logic [DW-1:0] o;
    o = '0;
    for (int i = 0; i < ENT; i++) if (c[i]) o[i % DW] = 1'b1;
    return o;
  endfunction

  function automatic logic [ENT-1:0] rand_ent();
    logic [ENT-1:0] v;
    for (int i = 0; i < ENT; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // Monitor: compares DUT outputs against whatever the driver queued for this cycle.
  initial begin
    forever begin
      @(negedge clk);
      while (comb_q.size() > 0 && comb_q[0].cyc == cyc) begin
        ce_mon = comb_q.pop_front();
        for (int p = 0; p < CMP; p++)
          chk($sformatf("ref_p%0d_c%0d", p, cyc), ref_out[p], ce_mon.refv[p]);
        for (int r = 0; r < RDP; r++)
          chk($sformatf("rdout_r%0d_c%0d", r, cyc), rd_out[r], ce_mon.rdo[r]);
      end
      while (stat_q.size() > 0 && stat_q[0].cyc == cyc) begin
        se_mon = stat_q.pop_front();
        chk($sformatf("sticky_c%0d", cyc), sticky, se_mon.sticky);
        chk($sformatf("cnt_c%0d", cyc), cnt, se_mon.cnt);
        chk($sformatf("vld_c%0d", cyc), ff_vld, se_mon.vld);
        chk($sformatf("ffport_c%0d", cyc), ff_port, se_mon.port);
        chk($sformatf("ffaddr_c%0d", cyc), ff_addr, se_mon.addr);
        chk($sformatf("ffentry_c%0d", cyc), ff_entry, se_mon.entry);
      end
    end
  end

  logic [CMP-1:0]          h_en   [NCYC];
  logic [CMP-1:0][1:0]     h_sel  [NCYC];
  logic [CMP-1:0][AW-1:0]  h_addr [NCYC];
  bit                      h_rst  [NCYC];

  logic                    flushed;
  logic                    a_en;
  logic [1:0]              a_sel;
  logic [AW-1:0]           a_addr;
  logic [ENT-1:0]          refp, mv;
  logic [CMP-1:0][ENT-1:0] cmpv;
  logic [CMP-1:0][AW-1:0]  afl;
  logic [CMP-1:0]          pf;
  logic [CMP-1:0]          m_sticky;
  int                      m_cnt, k;
  logic                    m_vld;
  logic [PW-1:0]           m_port;
  logic [AW-1:0]           m_addr, m_entry;
  logic [W_DW-1:0]         wexp;

  initial begin
    rst = 1'b1; mode = 1'b0; clr = 1'b0; en = '0; sel = '0; addr = '0;
    match = '0; rd_in = '0;
    w_rst = 1'b1; w_mode = 1'b0; w_clr = 1'b0; w_en = '0; w_sel = '0; w_addr = '0;
    w_match = '0; w_rd_in = '0;

    // Wide instance: data wider than the match line, so results sit in the MSBs.
    repeat (2) begin @(posedge clk); #1; end
    w_rst = 1'b0; w_en = 1'b1; w_sel[0] = 2'b00; w_addr[0] = 6'd3; w_mode = 1'b1; w_match[0] = '1;
    @(posedge clk); #1;
    w_match[0] = '1;
    w_match[0][0] = 1'b0;
    @(negedge clk);
    chk("wide_ref_all_ones", w_ref[0], {W_ENT{1'b1}});
    wexp = '0; wexp[8] = 1'b1;
    chk("wide_entry0_bit8", w_rd_out[0], wexp);
    @(posedge clk); #1;
    w_match[0] = '1;
    w_match[0][63] = 1'b0;
    @(negedge clk);
    wexp = '0; wexp[71] = 1'b1;
    chk("wide_entry63_bit71", w_rd_out[0], wexp);
    @(posedge clk); #1;
    w_mode = 1'b0;
    w_rd_in[0] = 72'hA5_1234_5678_9ABC_DEF0;
    @(negedge clk);
    chk("wide_mode0_passthru", w_rd_out[0], 72'hA5_1234_5678_9ABC_DEF0);
    chk("wide_cnt_two", w_cnt, 4'd2);
    chk("wide_vld", w_vld, 1'b1);
    chk("wide_ff_addr", w_ffaddr, 6'd3);
    chk("wide_ff_entry", w_ffentry, 6'd0);
    w_match[0] = '0;
    repeat (20) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("wide_cnt_saturated", w_cnt, 4'd15);
    chk("wide_sticky", w_sticky, 1'b1);
    @(posedge clk); #1;
    w_clr = 1'b1;
    @(posedge clk); #1;
    w_clr = 1'b0; w_en = '0;
    @(negedge clk);
    chk("wide_clr_cnt", w_cnt, 4'd0);
    chk("wide_clr_vld", w_vld, 1'b0);
    chk("wide_clr_sticky", w_sticky, 1'b0);
    chk("wide_clr_entry", w_ffentry, 6'd0);

    // Main instance: randomized run against the reference model.
    m_sticky = '0; m_cnt = 0; m_vld = 1'b0; m_port = '0; m_addr = '0; m_entry = '0;
    for (int t = 0; t < NCYC; t++) begin
      @(posedge clk); #1;
      cyc  = t;
      rst  = (t < 3) || ($urandom_range(0, 149) == 0);
      clr  = ($urandom_range(0, 39) == 0);
      mode = 1'($urandom_range(0, 1));
      for (int p = 0; p < CMP; p++) begin
        en[p]   = ($urandom_range(0, 9) < 7);
        sel[p]  = 2'($urandom_range(0, 3));
        addr[p] = AW'($urandom_range(0, 127));
      end
      for (int r = 0; r < RDP; r++) rd_in[r] = DW'({$urandom(), $urandom(), $urandom()});
      h_en[t] = en; h_sel[t] = sel; h_addr[t] = addr; h_rst[t] = rst;

      // A request is lost if reset was seen anywhere during its trip to alignment.
      flushed = (t < LAT);
      for (int s = t - LAT; s < t; s++) if (s >= 0 && h_rst[s]) flushed = 1'b1;

      for (int p = 0; p < CMP; p++) begin
        if (flushed) begin
          a_en = 1'b0; a_sel = 2'b00; a_addr = '0;
        end else begin
          a_en = h_en[t-LAT][p]; a_sel = h_sel[t-LAT][p]; a_addr = h_addr[t-LAT][p];
        end
        refp = ref_pat(a_sel, int'(a_addr));
        mv = refp;
        k = $urandom_range(0, 9);
        if (k < 2) mv[$urandom_range(0, ENT-1)] ^= 1'b1;
        else if (k == 2) begin
          mv[$urandom_range(0, ENT-1)] ^= 1'b1;
          mv[$urandom_range(0, ENT-1)] ^= 1'b1;
        end else if (k == 3) mv = rand_ent();
        match[p]   = mv;
        ce.refv[p] = refp;
        cmpv[p]    = refp ^ mv;
        pf[p]      = a_en && (cmpv[p] != '0);
        afl[p]     = a_addr;
      end
      for (int r = 0; r < RDP; r++)
        ce.rdo[r] = mode ? fold(cmpv[(r < CMP) ? r : 0]) : rd_in[r];
      ce.cyc = t;
      if (t >= 1) comb_q.push_back(ce);

      if (rst || clr) begin
        m_sticky = '0; m_cnt = 0; m_vld = 1'b0; m_port = '0; m_addr = '0; m_entry = '0;
      end else begin
        for (int p = 0; p < CMP; p++) begin
          if (pf[p]) begin
            m_sticky[p] = 1'b1;
            if (m_cnt < (1 << FW) - 1) m_cnt++;
          end
        end
        if (!m_vld && (pf != '0)) begin
          for (int p = CMP - 1; p >= 0; p--) if (pf[p]) m_port = PW'(p);
          m_vld  = 1'b1;
          m_addr = afl[m_port];
          for (int i = ENT - 1; i >= 0; i--) if (cmpv[m_port][i]) m_entry = AW'(i);
        end
      end
      se.cyc = t + 1; se.sticky = m_sticky; se.cnt = FW'(m_cnt); se.vld = m_vld;
      se.port = m_port; se.addr = m_addr; se.entry = m_entry;
      stat_q.push_back(se);
    end

    @(posedge clk); #1;
    cyc = NCYC;
    rst = 1'b1; clr = 1'b0; en = '0;
    repeat (2) @(negedge clk);
    chk("comb_q_drained", 128'(comb_q.size()), 128'd0);
    chk("stat_q_drained", 128'(stat_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
